inverter_pipe: RTL and testbench
================================

Name: inverter_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit conditional inverter.
- Supports four operand modes: pass, ones-complement, twos-complement negate, and absolute value.
- Moves data through a 2-stage valid/ready pipeline with full backpressure.
- Sits between the register-file read path and the ALU/branch comparator; it produces the conditioned operand and an overflow flag.

Parameters:
- WIDTH, 16, data width in bits; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents in_data/in_mode this cycle.
- in_ready  output  1  block accepts a transfer this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  2  00 pass, 01 invert, 10 negate, 11 abs.
- out_valid  output  1  out_data/out_ovf hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_data  output  WIDTH  conditioned operand.
- out_ovf  output  1  result not representable; see Behaviour.

Behaviour:
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) registers, loaded on an input transfer:
  - s1_data = in_data XOR {WIDTH{inv}}.
  - s1_cin.
  - s1_ovf.
  - s1_valid.
- How inv and cin are derived from in_mode:
  - pass: inv=0, cin=0.
  - invert: inv=1, cin=0.
  - negate: inv=1, cin=1.
  - abs: inv=cin=in_data[WIDTH-1].
- s1_ovf = 1 only when the mode is negate or abs and in_data == {1'b1,{WIDTH-1{1'b0}}} (most negative value).
- Stage 2 (S2) registers:
  - out_data = s1_data + s1_cin, truncated to WIDTH; the carry-out is discarded.
  - out_ovf = s1_ovf.
  - out_valid = s2_valid.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- S2 loads from S1 when s2_adv.
  - s2_valid takes s1_valid on that edge.
  - S1 loads the input when s1_adv, and s1_valid takes (in_valid && in_ready).
- Latency and throughput:
  - Latency from input transfer to out_valid is 2 cycles.
  - Throughput is 1 per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_data/out_ovf are held stable. S1 keeps its contents; if S1 is also full, in_ready=0.
- Simultaneous events:
  - An output transfer and an S1→S2 move in the same cycle preserve order and lose no data.
  - A new input may enter S1 in the same cycle S1 moves to S2.
- Reset:
  - Asserting rst at any time, including mid-stall, clears s1_valid, s2_valid, out_data, out_ovf and S1 data to 0 immediately.
  - Results in flight are discarded.
  - While rst=1, in_ready=1 (pipeline empty), but no transfer is captured.
- Data registers are updated only on a load; invalid slots keep their last value (don't-care) except after reset.
- Two's-complement arithmetic throughout; WIDTH-bit wrap.
- abs of the most negative value yields that same value with out_ovf=1, unless saturation is enabled (see Optional Feature).

Optional Feature:
- Macro: INVERTER_PIPE_SAT_EN.
- When defined:
  - In S2, if s1_ovf=1, out_data = {1'b0,{WIDTH-1{1'b1}}} (most positive value) instead of the wrapped sum.
  - out_ovf is still asserted.
- When undefined: wrap behaviour as above; no saturation logic is synthesised.

Test Plan:
- Reset and idle: WIDTH=16, assert rst for 2 cycles mid-operation with S1 and S2 full. Required response:
  - out_valid=0, out_data=0, out_ovf=0 immediately.
  - in_ready=1.
  - No stale result appears after rst falls.
- Mode sweep, back-to-back with out_ready=1: inputs 16'h00F0 pass, 16'h00F0 invert, 16'h0005 negate, 16'hFFFB abs. Required response, appearing 2 cycles after each input on consecutive cycles:
  - 16'h00F0.
  - 16'hFF0F.
  - 16'hFFFB.
  - 16'h0005.
  - All with out_ovf=0.
- Overflow: 16'h8000 negate, then 16'h8000 abs. Required response: out_ovf=1 on both.
  - Without the macro, out_data=16'h8000 for both.
  - With INVERTER_PIPE_SAT_EN, out_data=16'h7FFF for both.
- Backpressure: hold out_ready=0 while streaming 16'h0001, 16'h0002, 16'h0003 in negate mode. Required response:
  - in_ready falls after two accepts.
  - out_data=16'hFFFF is held stable.
  - Releasing out_ready yields 16'hFFFF, 16'hFFFE, 16'hFFFD in order, none lost or duplicated.
- Simultaneous in/out under toggling out_ready (random 50%): 200 random operands and modes. Required response: the output sequence equals the reference model's sequence exactly.
- Width generality: WIDTH=4, input 4'b1000 abs → 4'b1000 with ovf=1; input 4'b0011 negate → 4'b1101 with ovf=0.

Source files
------------

// File: rtl/inverter_pipe.sv
// rtl/inverter_pipe.sv - two-stage valid/ready operand conditioner (pass/invert/negate/abs); optional INVERTER_PIPE_SAT_EN saturates overflowed results
module inverter_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_NEGATE = 2'b10;
    localparam logic [1:0] MODE_ABS    = 2'b11;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef INVERTER_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_cin_q,   s1_cin_d;
    logic             s1_ovf_q,   s1_ovf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic             s2_ovf_q,   s2_ovf_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             inv;
    logic             cin;
    logic             ovf;
    logic [WIDTH-1:0] sum;

    // Stage advance: a stage may load when it is empty or its contents leave this cycle
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // Mode decode: conditional invert plus carry-in gives pass/ones/twos/abs
    always_comb begin
        inv = 1'b0;
        cin = 1'b0;
        case (in_mode)
            MODE_PASS:   begin inv = 1'b0;               cin = 1'b0;               end
            MODE_INVERT: begin inv = 1'b1;               cin = 1'b0;               end
            MODE_NEGATE: begin inv = 1'b1;               cin = 1'b1;               end
            MODE_ABS:    begin inv = in_data[WIDTH-1];   cin = in_data[WIDTH-1];   end
            default:     begin inv = 1'b0;               cin = 1'b0;               end
        endcase
        // negate/abs are the only modes with an arithmetic result; only MOST_NEG cannot be represented
        ovf = in_mode[1] && (in_data == MOST_NEG);
    end

    // Stage 2 adder: add the deferred carry-in, carry-out dropped (WIDTH-bit wrap)
    always_comb begin
        sum = s1_data_q + {{(WIDTH-1){1'b0}}, s1_cin_q};
    end

    // Next-state for both stages; data registers only change on an actual load
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cin_d   = s1_cin_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef INVERTER_PIPE_SAT_EN
                s2_data_d = s1_ovf_q ? MOST_POS : sum;
`else
                s2_data_d = sum;
`endif
                s2_ovf_d  = s1_ovf_q;
            end
        end

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data ^ {WIDTH{inv}};
                s1_cin_d  = cin;
                s1_ovf_d  = ovf;
            end
        end
    end

    // Pipeline registers; reset empties the pipe and discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cin_q   <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_cin_q   <= s1_cin_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    // Outputs come straight from stage 2 registers
    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_ovf   = s2_ovf_q;
    end

endmodule

// File: tb/tb_inverter_pipe.sv
// tb/tb_inverter_pipe.sv - directed and reference-model bench for inverter_pipe
module tb_inverter_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  in_data4;
    logic [1:0]  in_mode4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  out_data4;
    logic        out_ovf4;

    int total;
    int bad;

    inverter_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    inverter_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_ovf(out_ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: arithmetic meaning of each mode, ovf in bit 16
    function automatic logic [16:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [15:0] r;
        logic        o;
        case (m)
            2'd0:    r = d;
            2'd1:    r = ~d;
            2'd2:    r = 16'd0 - d;
            default: r = d[15] ? 16'd0 - d : d;
        endcase
        o = (m == 2'd2 || m == 2'd3) && (d == 16'h8000);
`ifdef INVERTER_PIPE_SAT_EN
        if (o) r = 16'h7FFF;
`endif
        return {o, r};
    endfunction

    logic [15:0] sw_d [4];
    logic [1:0]  sw_m [4];
    logic [15:0] sw_e [4];
    logic [15:0] ovf_e;
    logic [3:0]  abs4_e;
    logic [16:0] exp_q [$];
    logic [16:0] e;
    int sent;
    int cyc;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; in_mode4 = '0; out_ready4 = 1'b1;
        step();
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // Mode sweep, back to back, latency 2
        sw_d = '{16'h00F0, 16'h00F0, 16'h0005, 16'hFFFB};
        sw_m = '{2'd0, 2'd1, 2'd2, 2'd3};
        sw_e = '{16'h00F0, 16'hFF0F, 16'hFFFB, 16'h0005};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_data = sw_d[i]; in_mode = sw_m[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 2) begin
                chk("sweep_latency_valid", out_valid, 0);
            end else begin
                chk("sweep_valid", out_valid, 1);
                chk("sweep_data", out_data, sw_e[i-2]);
                chk("sweep_ovf", out_ovf, 0);
            end
            step();
        end
        chk("sweep_drained", out_valid, 0);

        // Overflow: most negative value under negate and abs
`ifdef INVERTER_PIPE_SAT_EN
        ovf_e = 16'h7FFF;
`else
        ovf_e = 16'h8000;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                in_valid = 1'b1; in_data = 16'h8000; in_mode = (i == 0) ? 2'd2 : 2'd3;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                chk("ovf_valid", out_valid, 1);
                chk("ovf_data", out_data, ovf_e);
                chk("ovf_flag", out_ovf, 1);
            end
            step();
        end
        step();

        // Backpressure: negate 1,2,3 with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd2; in_data = 16'h0001;
        #1;
        chk("bp_ready_empty", in_ready, 1);
        step();
        in_data = 16'h0002;
        #1;
        chk("bp_ready_one", in_ready, 1);
        step();
        in_data = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_full", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 16'hFFFF);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_out1", out_data, 16'hFFFF);
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_out2_valid", out_valid, 1);
        chk("bp_out2", out_data, 16'hFFFE);
        step();
        chk("bp_out3_valid", out_valid, 1);
        chk("bp_out3", out_data, 16'hFFFD);
        step();
        chk("bp_no_dup", out_valid, 0);

        // Reset mid-stall with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd0; in_data = 16'h1234;
        step();
        in_data = 16'h5678;
        step();
        #1;
        chk("prerst_full", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_data", out_data, 0);
        chk("rst_async_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        chk("rst_no_capture", out_valid, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_stale", out_valid, 0);
        end

        // Random traffic against the reference model
        sent = 0;
        cyc = 0;
        while ((sent < 200 || exp_q.size() != 0) && cyc < 5000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            if ($urandom_range(0, 9) == 0) in_data = 16'h8000;
            in_mode   = 2'($urandom_range(0, 3));
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_data", out_data, e[15:0]);
                    chk("rand_ovf", out_ovf, e[16]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_mode));
                sent++;
            end
            step();
            cyc++;
        end
        chk("rand_all_sent", sent, 200);
        chk("rand_queue_empty", exp_q.size(), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();

        // WIDTH=4 instance
`ifdef INVERTER_PIPE_SAT_EN
        abs4_e = 4'b0111;
`else
        abs4_e = 4'b1000;
`endif
        in_valid4 = 1'b1; in_data4 = 4'b1000; in_mode4 = 2'd3;
        step();
        in_data4 = 4'b0011; in_mode4 = 2'd2;
        step();
        in_valid4 = 1'b0;
        #1;
        chk("w4_abs_valid", out_valid4, 1);
        chk("w4_abs_data", out_data4, abs4_e);
        chk("w4_abs_ovf", out_ovf4, 1);
        step();
        chk("w4_neg_data", out_data4, 4'b1101);
        chk("w4_neg_ovf", out_ovf4, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
